// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, states and lane helpers for the data-memory initiator
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Lane 1 (MSB byte, bits 31:24) sits at mask bit 3, lane 4 (LSB byte) at bit 0
   localparam int LANE_MSB = 3;
   localparam int LANE_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Big-endian lane selection: byte offset 0 maps to lane 1 (mask bit 3)
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b1000 >> off;
         SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - big-endian byte/half select with zero or sign extension
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_signed,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte or half (offset 0 is the MSB lane) and extend it
   always_comb begin
      w_byte = 8'h00;
      w_half = 16'h0000;
      o_data = i_data;
      case (i_off)
         2'd0:    w_byte = i_data[8*LANE_MSB +: 8];
         2'd1:    w_byte = i_data[23:16];
         2'd2:    w_byte = i_data[15:8];
         default: w_byte = i_data[8*LANE_LSB +: 8];
      endcase
      w_half = i_off[1] ? i_data[15:0] : i_data[31:16];
      case (i_size)
         SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
         default: o_data = i_data;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage initiator for four byte-lane memories (option: MISALIGN_TRAP_EN)
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 8,
   parameter int ADDR_W      = 11
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_signed,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_resp_valid,
   output logic [31:0]       o_resp_rdata,
   output logic              o_resp_err,
   output logic              o_busy,
   output logic [3:0]        o_lane_rd_en,
   output logic [3:0]        o_lane_wr_en,
   output logic [ADDR_W-3:0] o_lane_addr,
   output logic [31:0]       o_lane_wdata,
   input  logic [31:0]       i_lane_rdata,
   input  logic [3:0]        i_lane_valid
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic              r_signed;
   logic              r_err;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic [3:0]        r_mask;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_accept;
   logic              w_hit;
   logic              w_tmo;
   logic              w_trap;
   logic [1:0]        w_size_n;
   logic [1:0]        w_off;
   logic [1:0]        w_off_al;
   logic [31:0]       w_ld_data;

   assign w_accept = i_req_valid & (r_state == IDLE);
   assign w_size_n = (i_req_size == 2'b11) ? SZ_WORD : i_req_size;
   assign w_off    = i_req_addr[1:0];
   assign w_hit    = ((i_lane_valid & r_mask) == r_mask);
   assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Force the low address bits onto the natural boundary of the access size
   always_comb begin
      w_off_al = w_off;
      if (w_size_n == SZ_HALF) begin
         w_off_al = {w_off[1], 1'b0};
      end else if (w_size_n == SZ_WORD) begin
         w_off_al = 2'b00;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // An access is misaligned exactly when alignment would have changed its offset
   assign w_trap = (w_off_al != w_off);
`else
   assign w_trap = 1'b0;
`endif

   dmem_load_align u_load_align (
      .i_data   (i_lane_rdata),
      .i_size   (r_size),
      .i_off    (r_addr[1:0]),
      .i_signed (r_signed),
      .o_data   (w_ld_data)
   );

   // State register; reset aborts any access in flight without a response
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Request latching, timeout counting and load-data capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_we     <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
         r_size   <= SZ_BYTE;
         r_addr   <= '0;
         r_wdata  <= 32'h0;
         r_rdata  <= 32'h0;
         r_mask   <= 4'h0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_we     <= i_req_we;
                  r_signed <= i_req_signed;
                  r_size   <= w_size_n;
                  r_addr   <= {i_req_addr[ADDR_W-1:2], w_off_al};
                  r_wdata  <= i_req_wdata;
                  r_rdata  <= 32'h0;
                  r_err    <= w_trap;
                  r_mask   <= w_trap ? 4'h0 : lane_mask(w_size_n, w_off_al);
               end
            end
            ISSUE: r_cnt <= '0;
            WAIT: begin
               if (w_hit) begin
                  if (!r_we) r_rdata <= w_ld_data;
               end else if (w_tmo) begin
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state decode and state-derived handshake/lane outputs
   always_comb begin
      w_next       = r_state;
      o_req_ready  = 1'b0;
      o_busy       = 1'b1;
      o_resp_valid = 1'b0;
      o_resp_err   = 1'b0;
      o_lane_rd_en = 4'h0;
      o_lane_wr_en = 4'h0;
      case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            o_busy      = 1'b0;
            if (w_accept) w_next = ISSUE;
         end
         ISSUE: begin
            if (r_we) o_lane_wr_en = r_mask;
            else      o_lane_rd_en = r_mask;
            w_next = r_err ? RESP : WAIT;
         end
         WAIT: begin
            if (w_hit || w_tmo) w_next = RESP;
         end
         default: begin
            o_resp_valid = 1'b1;
            o_resp_err   = r_err;
            w_next       = IDLE;
         end
      endcase
   end

   // Store data is replicated so whichever lanes are enabled see their byte
   always_comb begin
      case (r_size)
         SZ_BYTE: o_lane_wdata = {4{r_wdata[7:0]}};
         SZ_HALF: o_lane_wdata = {2{r_wdata[15:0]}};
         default: o_lane_wdata = r_wdata;
      endcase
   end

   assign o_lane_addr  = r_addr[ADDR_W-1:2];
   assign o_resp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed vector bench for dmem_access_ctrl with a byte-lane memory model
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [10:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic [3:0]  rd_en;
   logic [3:0]  wr_en;
   logic [8:0]  lane_addr;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;
   logic [3:0]  lane_valid;

   logic [3:0]  kill;
   logic [3:0]  stray;
   logic [31:0] mem [0:511];

   int tests = 0;
   int fails = 0;
   int cur   = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.TIMEOUT_CYC(8), .ADDR_W(11)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_size   (req_size),
      .i_req_signed (req_signed),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid),
      .o_resp_rdata (resp_rdata),
      .o_resp_err   (resp_err),
      .o_busy       (busy),
      .o_lane_rd_en (rd_en),
      .o_lane_wr_en (wr_en),
      .o_lane_addr  (lane_addr),
      .o_lane_wdata (lane_wdata),
      .i_lane_rdata (lane_rdata),
      .i_lane_valid (lane_valid)
   );

   // Four byte-lane memories: each lane answers one cycle after its enable
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_valid <= 4'h0;
         lane_rdata <= 32'h0;
         for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h11223344;
         mem[5] <= 32'h80FF1234;
         mem[7] <= 32'h01020304;
         mem[8] <= 32'hA0B0C0D0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) mem[lane_addr][8*i +: 8] <= lane_wdata[8*i +: 8];
            if (rd_en[i]) lane_rdata[8*i +: 8] <= mem[lane_addr][8*i +: 8];
         end
         lane_valid <= ((rd_en | wr_en) | stray) & ~kill;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic [3:0]  kill;
      logic [3:0]  stray;
      logic [3:0]  exp_mask;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [10:0] addr, input logic [31:0] wdata,
                               input logic [3:0] kl, input logic [3:0] st,
                               input logic [3:0] emask, input logic [31:0] erd,
                               input logic eerr, input int elat, input logic [31:0] ewd);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.kill = kl; v.stray = st; v.exp_mask = emask; v.exp_rdata = erd;
      v.exp_err = eerr; v.exp_lat = elat; v.exp_wdata = ewd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (vec %0d): got %h, expected %h", nm, cur, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          lat;
      int          en_cycles;
      logic        both;
      logic        seen_wr;
      logic [3:0]  seen_mask;
      logic [8:0]  seen_addr;
      logic [31:0] seen_wdata;
      logic [31:0] got_rdata;
      logic        got_err;
      lat = 0; en_cycles = 0; both = 1'b0; seen_wr = 1'b0; seen_mask = 4'h0;
      seen_addr = 9'h0; seen_wdata = 32'h0; got_rdata = 32'h0; got_err = 1'b0;
      @(negedge clk);
      kill  = v.kill;
      stray = v.stray;
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rd_en != 4'h0 && wr_en != 4'h0) both = 1'b1;
         if ((rd_en | wr_en) != 4'h0) begin
            en_cycles++;
            seen_mask  = rd_en | wr_en;
            seen_wr    = (wr_en != 4'h0);
            seen_addr  = lane_addr;
            seen_wdata = lane_wdata;
         end
         if (resp_valid) begin
            lat       = n;
            got_rdata = resp_rdata;
            got_err   = resp_err;
            break;
         end
      end
      chk("latency", lat, v.exp_lat);
      chk("resp_rdata", got_rdata, v.exp_rdata);
      chk("resp_err", {31'd0, got_err}, {31'd0, v.exp_err});
      chk("lane_mask", {28'd0, seen_mask}, {28'd0, v.exp_mask});
      chk("rd_wr_overlap", {31'd0, both}, 32'd0);
      chk("enable_cycles", en_cycles, (v.exp_mask != 4'h0) ? 1 : 0);
      if (v.exp_mask != 4'h0) begin
         chk("lane_addr", {23'd0, seen_addr}, {23'd0, v.addr[10:2]});
         chk("write_dir", {31'd0, seen_wr}, {31'd0, v.we});
         if (v.we) chk("lane_wdata", seen_wdata, v.exp_wdata);
      end
      @(negedge clk);
      chk("resp_pulse_width", {31'd0, resp_valid}, 32'd0);
      chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
      kill  = 4'h0;
      stray = 4'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen_resp;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 11'h0; req_wdata = 32'h0;
      kill = 4'h0; stray = 4'h0;

      //        we    size   sgn   addr    wdata          kill  stray  mask   rdata          err lat wdata
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 11'h014, 32'h0,         4'h0, 4'h0, 4'b1000, 32'hFFFFFF80, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 11'h017, 32'h0,         4'h0, 4'h0, 4'b0001, 32'h00000034, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 11'h016, 32'h0,         4'h0, 4'h0, 4'b0011, 32'h00001234, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 11'h014, 32'h0,         4'h0, 4'h0, 4'b1100, 32'hFFFF80FF, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 11'h014, 32'h0,         4'h0, 4'h0, 4'b1111, 32'h80FF1234, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 11'h015, 32'h0,         4'h0, 4'h0, 4'b0100, 32'hFFFFFFFF, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 11'h016, 32'h0,         4'h0, 4'b1101, 4'b0010, 32'h00000012, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 11'h01E, 32'h123456AB,  4'h0, 4'h0, 4'b0010, 32'h00000000, 1'b0, 3, 32'hABABABAB));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 11'h01C, 32'h0,         4'h0, 4'h0, 4'b1111, 32'h0102AB04, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 11'h022, 32'hFFFF5566,  4'h0, 4'h0, 4'b0011, 32'h00000000, 1'b0, 3, 32'h55665566));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 11'h020, 32'h0,         4'h0, 4'h0, 4'b1111, 32'hA0B05566, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 11'h014, 32'h0,         4'h0, 4'h0, 4'b1111, 32'h80FF1234, 1'b0, 3, 32'h0));
`ifdef MISALIGN_TRAP_EN
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 11'h002, 32'h0,         4'h0, 4'h0, 4'b0000, 32'h00000000, 1'b1, 2, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 11'h015, 32'h0,         4'h0, 4'h0, 4'b0000, 32'h00000000, 1'b1, 2, 32'h0));
`else
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 11'h002, 32'h0,         4'h0, 4'h0, 4'b1111, 32'h11223344, 1'b0, 3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 11'h015, 32'h0,         4'h0, 4'h0, 4'b1100, 32'h000080FF, 1'b0, 3, 32'h0));
`endif
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 11'h014, 32'h0,         4'b0001, 4'h0, 4'b1111, 32'h00000000, 1'b1, 10, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 11'h016, 32'h0,         4'h0, 4'h0, 4'b0011, 32'h00001234, 1'b0, 3, 32'h0));

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_enables", {24'd0, rd_en, wr_en}, 32'd0);
      chk("rst_lane_addr", {23'd0, lane_addr}, 32'd0);
      chk("rst_lane_wdata", lane_wdata, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         cur = i;
         run_vec(vecs[i]);
      end

      // Reset asserted while an access is outstanding
      cur = 100;
      @(negedge clk);
      kill       = 4'hF;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_addr   = 11'h014;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("issue_rd_en", {28'd0, rd_en}, 32'hF);
      @(negedge clk);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rd_en", {28'd0, rd_en}, 32'd0);
      chk("async_wr_en", {28'd0, wr_en}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_ready", {31'd0, req_ready}, 32'd1);
      seen_resp = 0;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid) seen_resp++;
      end
      rst  = 1'b0;
      kill = 4'h0;
      repeat (12) begin
         @(negedge clk);
         if (resp_valid) seen_resp++;
      end
      chk("no_resp_after_rst", seen_resp, 0);
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
